// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory responder slice.
//   - state_t   : responder FSM states (IDLE/WAIT/RESP)
//   - ADDR_W_DEF: default word address width
//   - DATA_W_DEF: default data word width
package mem_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array: synchronous word RAM with one read/write port (responder side)
// and one read-only port (debug). Both read outputs are registered.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset; clears output registers only
//   a_en     in   port A access strobe
//   a_we     in   port A 1 = write, 0 = read
//   a_addr   in   port A word address
//   a_wdata  in   port A write data
//   a_rdata  out  port A read data; loaded on a read access, held otherwise
//   b_addr   in   debug port address, read every cycle
//   b_rdata  out  debug port read data, 1-cycle latency
// Addresses at or above DEPTH read as 0, and writes to them are dropped.
module mem_array #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic             a_in_range;
    logic             b_in_range;
    logic [IDX_W-1:0] a_idx;
    logic [IDX_W-1:0] b_idx;

    assign a_in_range = 32'(a_addr) < 32'(DEPTH);
    assign b_in_range = 32'(b_addr) < 32'(DEPTH);
    assign a_idx      = a_addr[IDX_W-1:0];
    assign b_idx      = b_addr[IDX_W-1:0];

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (a_en && a_we && a_in_range) begin
            mem[a_idx] <= a_wdata;
        end
    end

    // Debug read samples the array before this edge's write lands,
    // so a same-address collision returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_en && !a_we) begin
                a_rdata <= a_in_range ? mem[a_idx] : '0;
            end
            b_rdata <= b_in_range ? mem[b_idx] : '0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: bus-side responder for the CPU memory port. Accepts one
// request at a time, waits WAIT_CYCLES states, then commits the write or
// returns read data together with a one-cycle ready pulse.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   req       in   request strobe, sampled only in IDLE
//   we        in   1 = write, 0 = read, captured with req
//   addr      in   word address, captured with req
//   din       in   write data, captured with req
//   dout      out  read data, updated only on read completion
//   ready     out  one-cycle completion pulse
//   busy      out  high whenever the FSM is not IDLE
//   dbg_addr  in   debug read address
//   dbg_data  out  debug read data, registered, 1-cycle latency
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              ready,
    output logic              busy,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              commit;

    // Commit happens on the edge that moves WAIT -> RESP; a reset on that
    // same edge aborts the transaction, so the array access is gated by rst.
    assign commit = (state == WAIT) && (cnt == 4'd0) && !rst;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q   <= we;
                        addr_q <= addr;
                        din_q  <= din;
                        cnt    <= 4'(WAIT_CYCLES);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Port A read register doubles as dout: it only loads on read commit.
    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk     (clk),
        .rst     (rst),
        .a_en    (commit),
        .a_we    (we_q),
        .a_addr  (addr_q),
        .a_wdata (din_q),
        .a_rdata (dout),
        .b_addr  (dbg_addr),
        .b_rdata (dbg_data)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized + directed bench for mem_responder.
// Two instances: u0 (WAIT_CYCLES=2, DEPTH=256) and u1 (WAIT_CYCLES=0,
// DEPTH=512). Each has a transaction-level reference model that predicts
// ready/busy/dout/dbg_data from acceptance edge numbers and a word array.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [2];
    logic        req_s   [2];
    logic        we_s    [2];
    logic [8:0]  addr_s  [2];
    logic [31:0] din_s   [2];
    logic [8:0]  dbg_s   [2];
    logic [31:0] dout_o  [2];
    logic        ready_o [2];
    logic        busy_o  [2];
    logic [31:0] dbg_o   [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int W = (g == 0) ? 2 : 0;
        localparam int D = (g == 0) ? 256 : 512;

        mem_responder #(
            .ADDR_W      (9),
            .DATA_W      (32),
            .DEPTH       (D),
            .WAIT_CYCLES (W)
        ) u_dut (
            .clk      (clk),
            .rst      (rst_s[g]),
            .req      (req_s[g]),
            .we       (we_s[g]),
            .addr     (addr_s[g]),
            .din      (din_s[g]),
            .dout     (dout_o[g]),
            .ready    (ready_o[g]),
            .busy     (busy_o[g]),
            .dbg_addr (dbg_s[g]),
            .dbg_data (dbg_o[g])
        );

        // Reference model: a transaction accepted at edge N completes at
        // edge N+W+1 and the responder is free again at edge N+W+2.
        logic [31:0] mref  [512];
        bit          known [512];
        int          e      = 0;
        int          done_e = 0;
        bit          pend   = 0;
        bit          was    = 0;
        bit          armed  = 0;
        logic        wq;
        logic [8:0]  aq;
        logic [31:0] dq;
        logic [31:0] x_dout, x_dbg;
        bit          x_ready, x_busy, k_dout, k_dbg;

        always @(posedge clk) begin
            e++;
            if (rst_s[g]) begin
                pend    = 0;
                x_ready = 0;
                x_busy  = 0;
                x_dout  = '0;
                k_dout  = 1;
                x_dbg   = '0;
                k_dbg   = 1;
                armed   = 1;
            end else begin
                was     = pend;
                k_dbg   = (int'(dbg_s[g]) >= D) || known[dbg_s[g]];
                x_dbg   = (int'(dbg_s[g]) < D) ? mref[dbg_s[g]] : '0;
                x_ready = 0;
                if (pend && e == done_e) begin
                    x_ready = 1;
                    if (wq) begin
                        if (int'(aq) < D) begin
                            mref[aq]  = dq;
                            known[aq] = 1;
                        end
                    end else begin
                        x_dout = (int'(aq) < D) ? mref[aq] : '0;
                        k_dout = (int'(aq) >= D) || known[aq];
                    end
                end
                if (pend && e == done_e + 1) pend = 0;
                if (!was && req_s[g]) begin
                    pend   = 1;
                    wq     = we_s[g];
                    aq     = addr_s[g];
                    dq     = din_s[g];
                    done_e = e + W + 1;
                end
                x_busy = pend;
            end
        end

        always @(negedge clk) begin
            if (armed) begin
                check($sformatf("u%0d.ready", g), 32'(ready_o[g]), 32'(x_ready));
                check($sformatf("u%0d.busy", g), 32'(busy_o[g]), 32'(x_busy));
                if (k_dout) check($sformatf("u%0d.dout", g), dout_o[g], x_dout);
                if (k_dbg)  check($sformatf("u%0d.dbg_data", g), dbg_o[g], x_dbg);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for `hold` edges, then scramble the inputs and idle.
    task automatic xact(input int g, input bit w, input logic [8:0] a,
                        input logic [31:0] d, input int hold);
        req_s[g]  = 1'b1;
        we_s[g]   = w;
        addr_s[g] = a;
        din_s[g]  = d;
        repeat (hold) tick();
        req_s[g]  = 1'b0;
        we_s[g]   = 1'($urandom);
        addr_s[g] = 9'($urandom);
        din_s[g]  = $urandom;
        repeat (6) tick();
    endtask

    task automatic run_inst(input int g);
        logic [8:0] a;
        // Write then read back with address changed after acceptance.
        dbg_s[g] = 9'd5;
        xact(g, 1'b1, 9'd5, 32'hDEADBEEF, 1);
        req_s[g] = 1'b1; we_s[g] = 1'b0; addr_s[g] = 9'd5;
        tick();
        req_s[g] = 1'b0; addr_s[g] = 9'd9;
        repeat (8) tick();
        // Held req with alternating writes/reads over addresses 0..3.
        req_s[g] = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            we_s[g]   = ~i[0];
            addr_s[g] = 9'(i % 4);
            din_s[g]  = $urandom;
            dbg_s[g]  = 9'(i % 4);
            tick();
        end
        req_s[g] = 1'b0;
        repeat (6) tick();
        // Reset during a write to 7 must leave the prior value in place.
        xact(g, 1'b1, 9'd7, 32'h11111111, 1);
        dbg_s[g] = 9'd7;
        req_s[g] = 1'b1; we_s[g] = 1'b1; addr_s[g] = 9'd7; din_s[g] = 32'h12345678;
        tick();
        req_s[g] = 1'b0;
        rst_s[g] = 1'b1;
        tick();
        rst_s[g] = 1'b0;
        repeat (4) tick();
        xact(g, 1'b0, 9'd7, 32'h0, 1);
        // Out-of-range accesses on the 256-word instance.
        xact(g, 1'b1, 9'd44, 32'hA5A5_0044, 1);
        xact(g, 1'b0, 9'd511, 32'h0, 1);
        xact(g, 1'b1, 9'd300, 32'hBAD0_0300, 1);
        dbg_s[g] = 9'd44;
        xact(g, 1'b0, 9'd300, 32'h0, 1);
        // Randomized traffic with occasional reset.
        for (int unsigned i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(200, 511))
                                            : 9'($urandom_range(0, 15));
            dbg_s[g] = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
            req_s[g]  = 1'b1;
            we_s[g]   = 1'($urandom);
            addr_s[g] = a;
            din_s[g]  = $urandom;
            repeat ($urandom_range(1, 4)) tick();
            req_s[g] = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                rst_s[g] = 1'b1;
                tick();
                rst_s[g] = 1'b0;
            end
            repeat ($urandom_range(0, 5)) tick();
        end
        repeat (6) tick();
    endtask

    initial begin
        for (int unsigned g = 0; g < 2; g++) begin
            rst_s[g]  = 1'b1;
            req_s[g]  = 1'b0;
            we_s[g]   = 1'b0;
            addr_s[g] = '0;
            din_s[g]  = '0;
            dbg_s[g]  = '0;
        end
        tick();
        tick();
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        repeat (10) tick();
        run_inst(0);
        run_inst(1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
